// File: rtl/stereo_pair_sequencer.sv
// Locks left/right AXIS video streams onto a common start of frame and releases beat pairs
// in lockstep, regenerating tuser/tlast from internal pixel/line counters.
module stereo_pair_sequencer #(
  parameter int HEIGHT                = 495,
  parameter int WIDTH                 = 740,
  parameter int MAX_SAMPLES_PER_CLOCK = 4,
  parameter int AXIS_TDATA_WIDTH      = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_l_tdata,
  input  logic                        s_axis_l_tvalid,
  input  logic                        s_axis_l_tuser,
  input  logic                        s_axis_l_tlast,
  output logic                        s_axis_l_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_r_tdata,
  input  logic                        s_axis_r_tvalid,
  input  logic                        s_axis_r_tuser,
  input  logic                        s_axis_r_tlast,
  output logic                        s_axis_r_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_l_tdata,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_r_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        frame_done,
  output logic [15:0]                 frame_count,
  output logic                        err_sof,
  output logic                        err_tlast,
  input  logic                        err_clear
);

  localparam int BEATS = WIDTH / MAX_SAMPLES_PER_CLOCK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);

  typedef enum logic {SEEK, RUN} state_t;

  state_t                      r_state;
  logic [BW-1:0]               r_beat;
  logic [LW-1:0]               r_line;
  logic                        r_mValid;
  logic                        r_mUser;
  logic                        r_mLast;
  logic [AXIS_TDATA_WIDTH-1:0] r_mDataL;
  logic [AXIS_TDATA_WIDTH-1:0] r_mDataR;
  logic                        r_frameDone;
  logic [15:0]                 r_frameCount;
  logic                        r_errSof;
  logic                        r_errTlast;

  logic w_outReady;
  logic w_bothValid;
  logic w_firstBeat;
  logic w_eol;
  logic w_eof;
  logic w_sofFault;
  logic w_fire;
  logic w_lock;
  logic w_lastFault;

  assign w_outReady  = !r_mValid | m_axis_tready;
  assign w_bothValid = s_axis_l_tvalid & s_axis_r_tvalid;
  assign w_firstBeat = (r_beat == '0) && (r_line == '0);
  assign w_eol       = (r_beat == LAST_BEAT);
  assign w_eof       = w_eol && (r_line == LAST_LINE);
  // A stray SOF mid-frame is left unconsumed so it can seed the next lock
  assign w_sofFault  = (r_state == RUN) & w_bothValid & (s_axis_l_tuser | s_axis_r_tuser) & !w_firstBeat;
  assign w_fire      = (r_state == RUN) & w_bothValid & w_outReady & !w_sofFault;
  assign w_lock      = (r_state == SEEK) & enable & w_bothValid & s_axis_l_tuser & s_axis_r_tuser;
  assign w_lastFault = w_fire & ((s_axis_l_tlast != w_eol) | (s_axis_r_tlast != w_eol));

  assign s_axis_l_tready = !areset & ((r_state == SEEK) ? (s_axis_l_tvalid & !s_axis_l_tuser) : w_fire);
  assign s_axis_r_tready = !areset & ((r_state == SEEK) ? (s_axis_r_tvalid & !s_axis_r_tuser) : w_fire);

  assign m_axis_l_tdata = r_mDataL;
  assign m_axis_r_tdata = r_mDataR;
  assign m_axis_tvalid  = r_mValid;
  assign m_axis_tuser   = r_mUser;
  assign m_axis_tlast   = r_mLast;
  assign frame_done     = r_frameDone;
  assign frame_count    = r_frameCount;
  assign err_sof        = r_errSof;
  assign err_tlast      = r_errTlast;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= SEEK;
      r_beat       <= '0;
      r_line       <= '0;
      r_mValid     <= 1'b0;
      r_mUser      <= 1'b0;
      r_mLast      <= 1'b0;
      r_mDataL     <= '0;
      r_mDataR     <= '0;
      r_frameDone  <= 1'b0;
      r_frameCount <= '0;
      r_errSof     <= 1'b0;
      r_errTlast   <= 1'b0;
    end else begin
      r_frameDone <= w_fire & w_eof;

      if (w_outReady) begin
        r_mValid <= w_fire;
        if (w_fire) begin
          r_mDataL <= s_axis_l_tdata;
          r_mDataR <= s_axis_r_tdata;
          r_mUser  <= w_firstBeat;
          r_mLast  <= w_eol;
        end
      end

      case (r_state)
        SEEK: begin
          if (w_lock) begin
            r_state <= RUN;
            r_beat  <= '0;
            r_line  <= '0;
          end
        end
        RUN: begin
          if (w_sofFault) begin
            r_state <= SEEK;
          end else if (w_fire) begin
            if (w_eol) begin
              r_beat <= '0;
              r_line <= w_eof ? '0 : r_line + 1'b1;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
            if (w_eof) begin
              r_state      <= SEEK;
              r_frameCount <= r_frameCount + 16'd1;
            end
          end
        end
        default: r_state <= SEEK;
      endcase

      // Clearing wins over a fault arriving in the same cycle
      if (err_clear) begin
        r_errSof   <= 1'b0;
        r_errTlast <= 1'b0;
      end else begin
        if (w_sofFault)  r_errSof   <= 1'b1;
        if (w_lastFault) r_errTlast <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stereo_pair_sequencer.sv
// Scoreboard bench for stereo_pair_sequencer using a small 8x3 frame (2 beats per line).
module tb_stereo_pair_sequencer;

  typedef struct packed {
    logic [31:0] d;
    logic        user;
    logic        last;
  } inBeat_t;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] l;
    logic [31:0] r;
  } outBeat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] s_axis_l_tdata = '0;
  logic        s_axis_l_tvalid = 1'b0;
  logic        s_axis_l_tuser = 1'b0;
  logic        s_axis_l_tlast = 1'b0;
  logic        s_axis_l_tready;
  logic [31:0] s_axis_r_tdata = '0;
  logic        s_axis_r_tvalid = 1'b0;
  logic        s_axis_r_tuser = 1'b0;
  logic        s_axis_r_tlast = 1'b0;
  logic        s_axis_r_tready;
  logic [31:0] m_axis_l_tdata;
  logic [31:0] m_axis_r_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        err_sof;
  logic        err_tlast;
  logic        err_clear = 1'b0;

  inBeat_t  lQ[$];
  inBeat_t  rQ[$];
  outBeat_t expQ[$];
  int checks = 0;
  int failures = 0;
  int doneCnt = 0;
  bit readyToggle = 1'b0;

  stereo_pair_sequencer #(
    .HEIGHT(3), .WIDTH(8), .MAX_SAMPLES_PER_CLOCK(4), .AXIS_TDATA_WIDTH(32)
  ) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_axis_l_tdata(s_axis_l_tdata), .s_axis_l_tvalid(s_axis_l_tvalid),
    .s_axis_l_tuser(s_axis_l_tuser), .s_axis_l_tlast(s_axis_l_tlast),
    .s_axis_l_tready(s_axis_l_tready),
    .s_axis_r_tdata(s_axis_r_tdata), .s_axis_r_tvalid(s_axis_r_tvalid),
    .s_axis_r_tuser(s_axis_r_tuser), .s_axis_r_tlast(s_axis_r_tlast),
    .s_axis_r_tready(s_axis_r_tready),
    .m_axis_l_tdata(m_axis_l_tdata), .m_axis_r_tdata(m_axis_r_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .frame_done(frame_done), .frame_count(frame_count),
    .err_sof(err_sof), .err_tlast(err_tlast), .err_clear(err_clear)
  );

  always #5 aclk = ~aclk;

  // Source drivers: handshakes sampled at negedge, queues advanced just after posedge
  initial begin
    bit lAcc, rAcc;
    forever begin
      @(negedge aclk);
      lAcc = s_axis_l_tvalid & s_axis_l_tready;
      rAcc = s_axis_r_tvalid & s_axis_r_tready;
      @(posedge aclk);
      #1;
      if (lAcc && lQ.size() > 0) void'(lQ.pop_front());
      if (rAcc && rQ.size() > 0) void'(rQ.pop_front());
      s_axis_l_tvalid = (lQ.size() > 0);
      if (lQ.size() > 0) {s_axis_l_tdata, s_axis_l_tuser, s_axis_l_tlast} = lQ[0];
      s_axis_r_tvalid = (rQ.size() > 0);
      if (rQ.size() > 0) {s_axis_r_tdata, s_axis_r_tuser, s_axis_r_tlast} = rQ[0];
      m_axis_tready = readyToggle ? ~m_axis_tready : 1'b1;
    end
  end

  // Output monitor: every valid cycle must match the head of the scoreboard, stalled or not
  always @(negedge aclk) begin
    if (!areset) begin
      if (frame_done) doneCnt++;
      if (m_axis_tvalid) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_output: got %h expected none",
                   {m_axis_tuser, m_axis_tlast, m_axis_l_tdata, m_axis_r_tdata});
        end else begin
          if ({m_axis_tuser, m_axis_tlast, m_axis_l_tdata, m_axis_r_tdata} !== expQ[0]) begin
            failures++;
            $display("[TB] FAIL output_beat: got %h expected %h",
                     {m_axis_tuser, m_axis_tlast, m_axis_l_tdata, m_axis_r_tdata}, expQ[0]);
          end
          if (m_axis_tready) void'(expQ.pop_front());
        end
      end
    end
  end

  // Queues one 6-beat frame; flipK marks the left beat whose tlast is corrupted
  task automatic pushFrame(input int f, input bit doL, input bit doR, input bit doExp, input int flipK);
    for (int k = 0; k < 6; k++) begin
      inBeat_t  b;
      outBeat_t o;
      if (doL) begin
        b.d = 32'hA000_0000 | 32'(f << 8) | 32'(k);
        b.user = (k == 0);
        b.last = (k % 2 == 1) ^ (k == flipK);
        lQ.push_back(b);
      end
      if (doR) begin
        b.d = 32'hB000_0000 | 32'(f << 8) | 32'(k);
        b.user = (k == 0);
        b.last = (k % 2 == 1);
        rQ.push_back(b);
      end
      if (doExp) begin
        o.user = (k == 0);
        o.last = (k % 2 == 1);
        o.l = 32'hA000_0000 | 32'(f << 8) | 32'(k);
        o.r = 32'hB000_0000 | 32'(f << 8) | 32'(k);
        expQ.push_back(o);
      end
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (!(expQ.size() == 0 && lQ.size() == 0 && rQ.size() == 0 && !m_axis_tvalid) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got %0d pending expected 0", name, expQ.size());
    end
    repeat (3) @(negedge aclk);
  endtask

  task automatic checkFrame(input string name, input int doneExp, input int startDone, input int countExp,
                            input bit sofExp, input bit tlastExp);
    checks += 4;
    if (doneCnt - startDone !== doneExp) begin
      failures++;
      $display("[TB] FAIL %s_frame_done: got %0d expected %0d", name, doneCnt - startDone, doneExp);
    end
    if (frame_count !== 16'(countExp)) begin
      failures++;
      $display("[TB] FAIL %s_frame_count: got %0d expected %0d", name, frame_count, countExp);
    end
    if (err_sof !== sofExp) begin
      failures++;
      $display("[TB] FAIL %s_err_sof: got %b expected %b", name, err_sof, sofExp);
    end
    if (err_tlast !== tlastExp) begin
      failures++;
      $display("[TB] FAIL %s_err_tlast: got %b expected %b", name, err_tlast, tlastExp);
    end
  endtask

  task automatic checkAllZero(input string name);
    checks++;
    if ({s_axis_l_tready, s_axis_r_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
         m_axis_l_tdata, m_axis_r_tdata, frame_done, frame_count, err_sof, err_tlast} !== '0) begin
      failures++;
      $display("[TB] FAIL %s_outputs: got lr=%b%b v=%b u=%b l=%b dl=%h dr=%h fd=%b fc=%0d es=%b et=%b expected all 0",
               name, s_axis_l_tready, s_axis_r_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
               m_axis_l_tdata, m_axis_r_tdata, frame_done, frame_count, err_sof, err_tlast);
    end
  endtask

  task automatic test_reset();
    inBeat_t b;
    b.d = 32'h1111_1111; b.user = 1'b0; b.last = 1'b0;
    lQ.push_back(b);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (s_axis_l_tvalid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_stimulus_valid: got %b expected 1", s_axis_l_tvalid);
    end
    checkAllZero("reset");
    @(posedge aclk); #1 areset = 1'b0;
    repeat (4) @(negedge aclk);
    checks++;
    if (lQ.size() !== 0) begin
      failures++;
      $display("[TB] FAIL seek_drop_after_reset: got %0d queued expected 0", lQ.size());
    end
  endtask

  task automatic test_aligned();
    int d0 = doneCnt;
    enable = 1'b1;
    pushFrame(1, 1, 1, 1, -1);
    waitDrain("aligned");
    checkFrame("aligned", 1, d0, 1, 0, 0);
  endtask

  task automatic test_skew();
    int d0 = doneCnt;
    pushFrame(2, 1, 0, 1, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      if (s_axis_l_tready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL skew_l_held_%0d: got tready %b expected 0", i, s_axis_l_tready);
      end
    end
    pushFrame(2, 0, 1, 0, -1);
    waitDrain("skew");
    checkFrame("skew", 1, d0, 2, 0, 0);
  endtask

  task automatic test_drop();
    int d0 = doneCnt;
    inBeat_t b;
    for (int i = 0; i < 3; i++) begin
      b.d = 32'hDEAD_0000 | 32'(i); b.user = 1'b0; b.last = (i == 1);
      lQ.push_back(b);
    end
    pushFrame(3, 1, 1, 1, -1);
    waitDrain("drop");
    checkFrame("drop", 1, d0, 3, 0, 0);
  endtask

  task automatic test_stall();
    int d0 = doneCnt;
    readyToggle = 1'b1;
    pushFrame(4, 1, 1, 1, -1);
    waitDrain("stall");
    readyToggle = 1'b0;
    checkFrame("stall", 1, d0, 4, 0, 0);
  endtask

  task automatic test_sof_fault();
    int d0 = doneCnt;
    inBeat_t  b;
    outBeat_t o;
    pushFrame(5, 1, 0, 0, -1);
    for (int k = 0; k < 3; k++) begin
      b.d = 32'hB000_0500 | 32'(k); b.user = (k == 0); b.last = (k == 1);
      rQ.push_back(b);
      o.user = (k == 0); o.last = (k == 1);
      o.l = 32'hA000_0500 | 32'(k); o.r = 32'hB000_0500 | 32'(k);
      expQ.push_back(o);
    end
    pushFrame(6, 1, 1, 1, -1);
    waitDrain("sof_fault");
    checkFrame("sof_fault", 1, d0, 5, 1, 0);
    @(posedge aclk); #1 err_clear = 1'b1;
    @(posedge aclk); #1 err_clear = 1'b0;
    @(negedge aclk);
    checks++;
    if (err_sof !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sof_clear: got %b expected 0", err_sof);
    end
  endtask

  task automatic test_tlast_fault();
    int d0 = doneCnt;
    pushFrame(7, 1, 1, 1, 0);
    waitDrain("tlast_fault");
    checkFrame("tlast_fault", 1, d0, 6, 0, 1);
    @(posedge aclk); #1 err_clear = 1'b1;
    @(posedge aclk); #1 err_clear = 1'b0;
    @(negedge aclk);
    checks++;
    if (err_tlast !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tlast_clear: got %b expected 0", err_tlast);
    end
  endtask

  task automatic test_enable_and_reset();
    int d0 = doneCnt;
    int n = 0;
    pushFrame(8, 1, 1, 1, -1);
    while (expQ.size() > 4 && n < 100) begin @(negedge aclk); n++; end
    enable = 1'b0;
    waitDrain("enable_off");
    checkFrame("enable_off", 1, d0, 7, 0, 0);
    pushFrame(9, 1, 1, 0, -1);
    repeat (20) @(negedge aclk);
    checks += 2;
    if (s_axis_l_tready !== 1'b0 || lQ.size() !== 6) begin
      failures++;
      $display("[TB] FAIL enable_off_no_lock: got tready %b queued %0d expected 0 and 6",
               s_axis_l_tready, lQ.size());
    end
    if (frame_count !== 16'd7) begin
      failures++;
      $display("[TB] FAIL enable_off_count: got %0d expected 7", frame_count);
    end
    pushFrame(9, 0, 0, 1, -1);
    enable = 1'b1;
    n = 0;
    while (expQ.size() > 3 && n < 100) begin @(negedge aclk); n++; end
    @(posedge aclk); #1 areset = 1'b1;
    lQ.delete(); rQ.delete(); expQ.delete();
    @(posedge aclk);
    @(negedge aclk);
    checkAllZero("mid_frame_reset");
    @(posedge aclk); #1 areset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skew();
    test_drop();
    test_stall();
    test_sof_fault();
    test_tlast_fault();
    test_enable_and_reset();
    repeat (3) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
